exec_ctrl: RTL and testbench
============================

EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be asynchronous and active-low: clk in 1, system clock, all state on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 run  in  1  advance enable; 0 freezes the cycle state.
REQ-004 romNibble  in  4  ROM bus nibble; OPR valid in M1, OPA valid in M2.
REQ-005 cycleState  out  3  current phase: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
REQ-006 sync  out  1  high while cycleState==X3.
REQ-007 aluOp  out  4  ALU main opcode.
REQ-008 aluSubOp  out  4  ALU sub-opcode, equal to the latched OPA.
REQ-009 opaOut  out  4  latched first-word OPA.
REQ-010 secondCycle  out  1  high during the second machine cycle of a two-cycle instruction.
REQ-011 addrOpr, addrOpa  out  4 each  second-word nibbles, latched in the second cycle.
REQ-012 pcInc, accWe, carryWe, regWe  out  1 each  single-clk write/step pulses.

Function
REQ-013 cycleState SHALL advance A1→A2→…→X3→A1 by one phase per clk while run=1, and SHALL hold while run=0.
REQ-014 With run=0, every pulse output SHALL be 0.
REQ-015 pcInc SHALL pulse for exactly one clk in A3 of every machine cycle.
REQ-016 First cycle, M1: romNibble SHALL latch into opr; M2: romNibble SHALL latch into opaOut.
REQ-017 Second cycle: M1 and M2 SHALL latch romNibble into addrOpr and addrOpa; opr and opaOut SHALL hold.
REQ-018 aluOp SHALL equal opr from X1 to X3 of a first cycle, and SHALL be NOP (0) at all other times, including all of a second cycle.
REQ-019 The two-cycle set SHALL be: JCN(1), JUN(4), JMS(5) and ISZ(7), plus FIM(2) and FIN(3) when OPA[0]=0.
REQ-020 The two-cycle decision SHALL be made at the end of M2 of the first cycle; secondCycle SHALL rise at the following A1 and fall at the A1 after that cycle's X3.
REQ-021 accWe SHALL pulse once in X2 of a first cycle for these cases:
- opr ∈ {ADD, SUB, LD, LDM, BBL, XCH};
- opr=F_ with OPA ≠ DCL (0xD) and OPA ≤ 0xD;
- opr=E_ with OPA ∈ {8,9,A,B,C,D,E,F}.
REQ-022 carryWe SHALL pulse once in X2 of a first cycle for opr ∈ {ADD, SUB}, or opr=F_ with OPA ∈ {0,1,2,3,5,6,7,8,9,A,B}.
REQ-023 regWe SHALL pulse once in X2 of a first cycle for opr ∈ {INC, XCH}.
REQ-024 regWe SHALL pulse once in X2 of the second cycle for opr=ISZ.
REQ-025 accWe, carryWe and regWe SHALL never pulse in a second cycle other than REQ-024.
REQ-026 A run=0 stall mid-phase SHALL only delay pulses; each pulse SHALL still occur exactly once, on the first clk that phase is active with run=1.
REQ-027 Undefined F_ sub-ops (OPA=E,F) SHALL produce no write pulses.

Reset
REQ-028 While rst_n=0, the block SHALL hold cycleState=A1; opr, opaOut, addrOpr and addrOpa =0; secondCycle=0; aluOp=NOP; sync=0; all pulses=0.
REQ-029 Reset asserted mid-instruction SHALL abort it, including a pending second cycle.
REQ-030 After reset release, the first clk with run=1 SHALL move the block to A2.

Structure
REQ-031 Opcode constants (NOP..F_), F_ and E_ sub-codes, and the cycle-state encoding SHALL reside in shared package tb4004_pkg, which the ALU also uses.
REQ-032 The write-enable and two-cycle decode SHALL be a combinational sub-module exec_decode (inputs opr, opa, secondCycle); phase sequencing and latches SHALL stay in exec_ctrl.

Verification
REQ-033 Reset then run=1 for 16 clk -> cycleState sequence 0..7,0..7; sync high at clk 8 and 16; pcInc at clk 3 and 11.
REQ-034 OPR=8, OPA=3 (ADD R3) -> aluOp=8 in X1–X3; accWe and carryWe in X2; regWe=0; secondCycle stays 0.
REQ-035 JUN with words 0x4,0x2 then 0x5,0xA -> secondCycle=1 for the next 8 phases; addrOpr=5, addrOpa=A; aluOp=0 and no acc/carry pulses.
REQ-036 ISZ (0x7,0x1) then 0x3,0x0 -> no regWe in the first cycle; one regWe in second-cycle X2.
REQ-037 F_ OPA=D (DCL) -> aluOp=F, aluSubOp=D, accWe=0, carryWe=0; F_ OPA=4 (CMA) -> accWe=1, carryWe=0.
REQ-038 run=0 for 3 clk during X2 of LDM, then rst_n pulse during a FIM-even second cycle -> accWe exactly once; after reset, cycleState=A1 and secondCycle=0.

Source files
------------

// File: rtl/tb4004_pkg.sv
// Shared 4004-style definitions: cycle phases, main opcodes, E_/F_ sub-codes
// and the two-cycle instruction test used by the execution control and ALU.
package tb4004_pkg;

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } cycle_state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JCN = 4'h1;
  localparam logic [3:0] OP_FIM = 4'h2;
  localparam logic [3:0] OP_FIN = 4'h3;
  localparam logic [3:0] OP_JUN = 4'h4;
  localparam logic [3:0] OP_JMS = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_ISZ = 4'h7;
  localparam logic [3:0] OP_ADD = 4'h8;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_XCH = 4'hB;
  localparam logic [3:0] OP_BBL = 4'hC;
  localparam logic [3:0] OP_LDM = 4'hD;
  localparam logic [3:0] OP_E   = 4'hE;
  localparam logic [3:0] OP_F   = 4'hF;

  // F_ (accumulator group) sub-codes; E and F are undefined
  localparam logic [3:0] F_CLB = 4'h0;
  localparam logic [3:0] F_CLC = 4'h1;
  localparam logic [3:0] F_IAC = 4'h2;
  localparam logic [3:0] F_CMC = 4'h3;
  localparam logic [3:0] F_CMA = 4'h4;
  localparam logic [3:0] F_RAL = 4'h5;
  localparam logic [3:0] F_RAR = 4'h6;
  localparam logic [3:0] F_TCC = 4'h7;
  localparam logic [3:0] F_DAC = 4'h8;
  localparam logic [3:0] F_TCS = 4'h9;
  localparam logic [3:0] F_STC = 4'hA;
  localparam logic [3:0] F_DAA = 4'hB;
  localparam logic [3:0] F_KBP = 4'hC;
  localparam logic [3:0] F_DCL = 4'hD;

  // E_ (I/O and RAM group) sub-codes
  localparam logic [3:0] E_WRM = 4'h0;
  localparam logic [3:0] E_WMP = 4'h1;
  localparam logic [3:0] E_WRR = 4'h2;
  localparam logic [3:0] E_WPM = 4'h3;
  localparam logic [3:0] E_WR0 = 4'h4;
  localparam logic [3:0] E_WR1 = 4'h5;
  localparam logic [3:0] E_WR2 = 4'h6;
  localparam logic [3:0] E_WR3 = 4'h7;
  localparam logic [3:0] E_SBM = 4'h8;
  localparam logic [3:0] E_RDM = 4'h9;
  localparam logic [3:0] E_RDR = 4'hA;
  localparam logic [3:0] E_ADM = 4'hB;
  localparam logic [3:0] E_RD0 = 4'hC;
  localparam logic [3:0] E_RD1 = 4'hD;
  localparam logic [3:0] E_RD2 = 4'hE;
  localparam logic [3:0] E_RD3 = 4'hF;

  // FIM/FIN share opcodes with SRC/JIN; only the even-OPA forms fetch a second word
  function automatic logic is_two_cycle(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == OP_JCN) || (opr == OP_JUN) || (opr == OP_JMS) || (opr == OP_ISZ) ||
           (((opr == OP_FIM) || (opr == OP_FIN)) && !opa[0]);
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Bus between the execution control block and its surroundings: ROM nibble
// and run enable in, phase / decode / write-strobe information out.
interface exec_ctrl_if;
  import tb4004_pkg::*;

  logic         run;
  logic [3:0]   romNibble;
  cycle_state_t cycleState;
  logic         sync;
  logic [3:0]   aluOp;
  logic [3:0]   aluSubOp;
  logic [3:0]   opaOut;
  logic         secondCycle;
  logic [3:0]   addrOpr;
  logic [3:0]   addrOpa;
  logic         pcInc;
  logic         accWe;
  logic         carryWe;
  logic         regWe;

  modport master (
    output run, romNibble,
    input  cycleState, sync, aluOp, aluSubOp, opaOut, secondCycle,
    input  addrOpr, addrOpa, pcInc, accWe, carryWe, regWe
  );

  modport slave (
    input  run, romNibble,
    output cycleState, sync, aluOp, aluSubOp, opaOut, secondCycle,
    output addrOpr, addrOpa, pcInc, accWe, carryWe, regWe
  );
endinterface

// File: rtl/exec_decode.sv
// Combinational instruction decode: two-cycle detection and write-enable
// qualifiers. The caller gates the enables with phase and run.
module exec_decode
  import tb4004_pkg::*;
(
  input  logic [3:0] i_opr,
  input  logic [3:0] i_opa,
  input  logic       i_second_cycle,
  output logic       o_two_cycle,
  output logic       o_acc_we,
  output logic       o_carry_we,
  output logic       o_reg_we
);

  // Decode the opcode pair; a second cycle only ever writes the ISZ register
  always_comb begin
    o_two_cycle = 1'b0;
    o_acc_we    = 1'b0;
    o_carry_we  = 1'b0;
    o_reg_we    = 1'b0;
    if (i_second_cycle) begin
      o_reg_we = (i_opr == OP_ISZ);
    end else begin
      o_two_cycle = is_two_cycle(i_opr, i_opa);
      unique case (i_opr)
        OP_ADD, OP_SUB: begin
          o_acc_we   = 1'b1;
          o_carry_we = 1'b1;
        end
        OP_LD, OP_LDM, OP_BBL: o_acc_we = 1'b1;
        OP_XCH: begin
          o_acc_we = 1'b1;
          o_reg_we = 1'b1;
        end
        OP_INC: o_reg_we = 1'b1;
        OP_E:   o_acc_we = (i_opa >= E_SBM);
        OP_F: begin
          // DCL only selects a RAM bank; E/F are undefined and write nothing
          o_acc_we   = (i_opa <= F_KBP);
          o_carry_we = (i_opa <= F_DAA) && (i_opa != F_CMA);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exec_ctrl.sv
// Execution control: eight-phase machine-cycle sequencer, instruction word
// latches and single-clock write/step strobes.
//
// state | meaning
// A1-A3 | address out; PC steps in A3
// M1    | OPR (or second-word OPR) on ROM bus
// M2    | OPA (or second-word OPA) on ROM bus
// X1-X3 | execute; writes in X2, sync in X3
module exec_ctrl
  import tb4004_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  exec_ctrl_if.slave  bus
);

  cycle_state_t r_state;
  logic [3:0]   r_opr;
  logic [3:0]   r_opa;
  logic [3:0]   r_addr_opr;
  logic [3:0]   r_addr_opa;
  logic         r_second;
  logic         r_pend;

  logic [3:0]   w_dec_opa;
  logic         w_two_cycle;
  logic         w_acc_we;
  logic         w_carry_we;
  logic         w_reg_we;
  logic         w_x2_step;

  // During M2 the OPA is still on the bus, so the two-cycle test looks at it directly
  assign w_dec_opa = (r_state == M2) ? bus.romNibble : r_opa;

  exec_decode u_decode (
    .i_opr          (r_opr),
    .i_opa          (w_dec_opa),
    .i_second_cycle (r_second),
    .o_two_cycle    (w_two_cycle),
    .o_acc_we       (w_acc_we),
    .o_carry_we     (w_carry_we),
    .o_reg_we       (w_reg_we)
  );

  // Phase sequencer and word latches; everything freezes while run is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= A1;
      r_opr      <= OP_NOP;
      r_opa      <= 4'h0;
      r_addr_opr <= 4'h0;
      r_addr_opa <= 4'h0;
      r_second   <= 1'b0;
      r_pend     <= 1'b0;
    end else if (bus.run) begin
      unique case (r_state)
        A1: r_state <= A2;
        A2: r_state <= A3;
        A3: r_state <= M1;
        M1: begin
          r_state <= M2;
          if (r_second) r_addr_opr <= bus.romNibble;
          else          r_opr      <= bus.romNibble;
        end
        M2: begin
          r_state <= X1;
          r_pend  <= w_two_cycle;
          if (r_second) r_addr_opa <= bus.romNibble;
          else          r_opa      <= bus.romNibble;
        end
        X1: r_state <= X2;
        X2: r_state <= X3;
        X3: begin
          r_state  <= A1;
          r_second <= r_pend;
          r_pend   <= 1'b0;
        end
        default: r_state <= A1;
      endcase
    end
  end

  // Strobes combine registered phase with the live run so a stalled phase fires
  // exactly once, on the clock it is finally allowed to complete
  assign w_x2_step = bus.run && (r_state == X2);

  assign bus.cycleState  = r_state;
  assign bus.sync        = (r_state == X3);
  assign bus.aluOp       = (!r_second && (r_state inside {X1, X2, X3})) ? r_opr : OP_NOP;
  assign bus.aluSubOp    = r_opa;
  assign bus.opaOut      = r_opa;
  assign bus.secondCycle = r_second;
  assign bus.addrOpr     = r_addr_opr;
  assign bus.addrOpa     = r_addr_opa;
  assign bus.pcInc       = bus.run && (r_state == A3);
  assign bus.accWe       = w_x2_step && w_acc_we;
  assign bus.carryWe     = w_x2_step && w_carry_we;
  assign bus.regWe       = w_x2_step && w_reg_we;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: stimulus pushes per-clock expected outputs,
// a negedge monitor pops and compares them.
module tb_exec_ctrl;

  logic clk;
  logic rst_n;

  exec_ctrl_if bus ();

  exec_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       sync;
    logic       pc;
    logic       acc;
    logic       carry;
    logic       rg;
    logic       sec;
    logic [3:0] alu;
    logic [3:0] opa;
    logic [3:0] aopr;
    logic [3:0] aopa;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   vec = 0;

  // expected contents of the word latches
  logic [3:0] m_opa  = 4'h0;
  logic [3:0] m_aopr = 4'h0;
  logic [3:0] m_aopa = 4'h0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at vector %0d: got %h expected %h", nm, vec, act, exp);
    end
  endtask

  // monitor: one expected record per clock
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("cycleState",  {1'b0, bus.cycleState}, {1'b0, e.st});
      chk("sync",        {3'b0, bus.sync},       {3'b0, e.sync});
      chk("pcInc",       {3'b0, bus.pcInc},      {3'b0, e.pc});
      chk("accWe",       {3'b0, bus.accWe},      {3'b0, e.acc});
      chk("carryWe",     {3'b0, bus.carryWe},    {3'b0, e.carry});
      chk("regWe",       {3'b0, bus.regWe},      {3'b0, e.rg});
      chk("secondCycle", {3'b0, bus.secondCycle},{3'b0, e.sec});
      chk("aluOp",       bus.aluOp,    e.alu);
      chk("aluSubOp",    bus.aluSubOp, e.opa);
      chk("opaOut",      bus.opaOut,   e.opa);
      chk("addrOpr",     bus.addrOpr,  e.aopr);
      chk("addrOpa",     bus.addrOpa,  e.aopa);
      vec++;
    end
  end

  task automatic step(input logic rn, input logic ru, input logic [3:0] nib, input exp_t e);
    @(posedge clk);
    #1;
    rst_n         = rn;
    bus.run       = ru;
    bus.romNibble = nib;
    sb.push_back(e);
  endtask

  function automatic exp_t mk(input int p, input logic live, input logic sec,
                              input logic [3:0] alu, input logic acc,
                              input logic carry, input logic rg);
    exp_t e;
    e.st    = p[2:0];
    e.sync  = (p == 7);
    e.pc    = live && (p == 2);
    e.acc   = live && (p == 6) && acc;
    e.carry = live && (p == 6) && carry;
    e.rg    = live && (p == 6) && rg;
    e.sec   = sec;
    e.alu   = (p >= 5) ? alu : 4'h0;
    e.opa   = m_opa;
    e.aopr  = m_aopr;
    e.aopa  = m_aopa;
    return e;
  endfunction

  // One machine cycle: w1 in M1, w2 in M2; optional run=0 stall before phase stall_p
  task automatic mcycle(input logic [3:0] w1, input logic [3:0] w2, input logic sec,
                        input logic [3:0] alu, input logic acc, input logic carry,
                        input logic rg, input int stall_p, input int stall_n, input int n_ph);
    logic [3:0] nib;
    for (int p = 0; p < n_ph; p++) begin
      nib = (p == 3) ? w1 : (p == 4) ? w2 : 4'h0;
      if (p == stall_p)
        for (int s = 0; s < stall_n; s++)
          step(1'b1, 1'b0, nib, mk(p, 1'b0, sec, alu, acc, carry, rg));
      step(1'b1, 1'b1, nib, mk(p, 1'b1, sec, alu, acc, carry, rg));
      if (p == 3 && sec) m_aopr = w1;
      if (p == 4) begin
        if (sec) m_aopa = w2;
        else     m_opa  = w2;
      end
    end
  endtask

  task automatic reset_step();
    exp_t e;
    m_opa  = 4'h0;
    m_aopr = 4'h0;
    m_aopa = 4'h0;
    e = mk(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'hF, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.romNibble = 4'h0;

    // held in reset with run high and a busy bus
    repeat (3) reset_step();

    // two NOP cycles: phase sequence, sync, pcInc
    mcycle(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    mcycle(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    // ADD R3
    mcycle(4'h8, 4'h3, 1'b0, 4'h8, 1'b1, 1'b1, 1'b0, -1, 0, 8);
    // JUN 0x2 / 0x5A
    mcycle(4'h4, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    mcycle(4'h5, 4'hA, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    // ISZ R1 / 0x30
    mcycle(4'h7, 4'h1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    mcycle(4'h3, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, -1, 0, 8);
    // DCL, CMA, KBP, undefined F_E
    mcycle(4'hF, 4'hD, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    mcycle(4'hF, 4'h4, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, -1, 0, 8);
    mcycle(4'hF, 4'hC, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, -1, 0, 8);
    mcycle(4'hF, 4'hE, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    // INC R5 with a stall in A3, XCH R2
    mcycle(4'h6, 4'h5, 1'b0, 4'h6, 1'b0, 1'b0, 1'b1, 2, 2, 8);
    mcycle(4'hB, 4'h2, 1'b0, 4'hB, 1'b1, 1'b0, 1'b1, -1, 0, 8);
    // WRR (no write), RDM (acc), JIN odd (single cycle)
    mcycle(4'hE, 4'h2, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    mcycle(4'hE, 4'h9, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0, -1, 0, 8);
    mcycle(4'h3, 4'h1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    // LDM 7 stalled 3 clk in X2
    mcycle(4'hD, 4'h7, 1'b0, 4'hD, 1'b1, 1'b0, 1'b0, 6, 3, 8);
    // FIM even, reset during the second cycle
    mcycle(4'h2, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, -1, 0, 8);
    mcycle(4'h9, 4'h6, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, -1, 0, 4);
    reset_step();
    // restart from A1 with no pending second cycle
    mcycle(4'hA, 4'h4, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, -1, 0, 8);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
